// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch/issue front end.
//   - opcode class constants (bits [6:0] of an instruction)
//   - front-end state encoding
//   - prefetch FIFO entry layout {pc, instr}
//   - immediate decoders for B-type and J-type instructions
package riscv_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_FETCH   = 2'd1;
   localparam logic [1:0] ST_WAIT_BR = 2'd2;
   localparam logic [1:0] ST_HALT    = 2'd3;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] imm_b(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] instr);
      return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/riscv_prefetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs between instruction memory and issue.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   flush_i       : synchronous clear; wins over a simultaneous push/pop
//   push_i/wdata_i: write one 64-bit entry
//   pop_i         : advance the head (caller guarantees non-empty)
//   rdata_o       : head entry (registered storage, no write-to-read bypass)
//   count_o       : number of valid entries
//   empty_o       : count_o == 0
module riscv_prefetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [63:0]            wdata_i,
   input  logic                   pop_i,
   output logic [63:0]            rdata_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [63:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
            2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by the pointers/count.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/riscv_fetch_issue.sv
// Instruction fetch-and-issue front end feeding the core's push interface.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   run               : level enable for fetch/issue
//   imem_en/imem_addr : read strobe and word address to instruction SRAM
//   imem_rdata        : SRAM read data, valid the cycle after imem_en
//   push_ops/opcode/issue_pc : registered issue of one instruction per cycle
//   branch_taken      : core's registered branch outcome
//   halted            : registered, high once a JALR/SYSTEM has been issued
module riscv_fetch_issue
   import riscv_pkg::*;
#(
   parameter int          IMEM_AW    = 10,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = 32'h0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               run,
   output logic               imem_en,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [31:0]        imem_rdata,
   output logic               push_ops,
   output logic [31:0]        opcode,
   output logic [31:0]        issue_pc,
   input  logic               branch_taken,
   output logic               halted
);

   localparam int          CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);
   // Byte-address space covered by the instruction memory; PCs wrap inside it.
   localparam logic [31:0] PC_MASK = (32'h1 << (IMEM_AW + 2)) - 32'h1;

   logic [1:0]  state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        epoch_q, epoch_d;
   logic        wcnt_q, wcnt_d;
   logic        rd_vld_q;
   logic [31:0] rd_pc_q;
   logic        rd_epoch_q;
   logic        push_q;
   logic [31:0] opcode_q;
   logic [31:0] issue_pc_q;
   logic        halted_q;
   logic [31:0] br_pc_q;
   logic [31:0] br_imm_q;

   logic             fetch_go;
   logic             pop;
   logic             flush;
   logic             wr_en;
   logic [63:0]      fifo_rdata;
   logic [CNT_W-1:0] fifo_cnt;
   logic             fifo_empty;
   logic [CNT_W:0]   occ;
   fetch_entry_t     head;
   logic [6:0]       head_op;
   logic [31:0]      pc_inc;
   logic [31:0]      jal_tgt;
   logic [31:0]      br_tgt;

   riscv_prefetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush_i (flush),
      .push_i  (wr_en),
      .wdata_i ({rd_pc_q, imem_rdata}),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .count_o (fifo_cnt),
      .empty_o (fifo_empty)
   );

   assign head    = fetch_entry_t'(fifo_rdata);
   assign head_op = head.instr[6:0];

   // Reserve a FIFO slot for every outstanding read so returning data always fits.
   assign occ      = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, rd_vld_q};
   assign fetch_go = ((state_q == ST_FETCH) || (state_q == ST_WAIT_BR)) && (occ < DEPTH_L);
   assign pop      = (state_q == ST_FETCH) && !fifo_empty;
   // Reads issued before a redirect carry the old epoch and are dropped here.
   assign wr_en    = rd_vld_q && (rd_epoch_q == epoch_q);

   assign pc_inc  = (fetch_pc_q + 32'd4) & PC_MASK;
   assign jal_tgt = (head.pc + imm_j(head.instr)) & PC_MASK;
   assign br_tgt  = (br_pc_q + br_imm_q) & PC_MASK;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_go ? pc_inc : fetch_pc_q;
      epoch_d    = epoch_q;
      wcnt_d     = wcnt_q;
      flush      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            state_d = run ? ST_FETCH : ST_IDLE;
            if (pop) begin
               if (head_op == OP_JAL) begin
                  fetch_pc_d = jal_tgt;
                  flush      = 1'b1;
                  epoch_d    = ~epoch_q;
               end else if (head_op == OP_BRANCH) begin
                  state_d = ST_WAIT_BR;
                  wcnt_d  = 1'b0;
               end else if ((head_op == OP_JALR) || (head_op == OP_SYSTEM)) begin
                  state_d = ST_HALT;
               end
            end
         end
         ST_WAIT_BR: begin
            // First edge lets the core evaluate; the second edge samples its result.
            if (!wcnt_q) begin
               wcnt_d = 1'b1;
            end else begin
               state_d = run ? ST_FETCH : ST_IDLE;
               if (branch_taken) begin
                  fetch_pc_d = br_tgt;
                  flush      = 1'b1;
                  epoch_d    = ~epoch_q;
               end
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         epoch_q    <= 1'b0;
         wcnt_q     <= 1'b0;
         rd_vld_q   <= 1'b0;
         rd_pc_q    <= '0;
         rd_epoch_q <= 1'b0;
         push_q     <= 1'b0;
         opcode_q   <= '0;
         issue_pc_q <= '0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         epoch_q    <= epoch_d;
         wcnt_q     <= wcnt_d;
         rd_vld_q   <= fetch_go;
         if (fetch_go) begin
            rd_pc_q    <= fetch_pc_q;
            rd_epoch_q <= epoch_q;
         end
         push_q <= pop;
         if (pop) begin
            opcode_q   <= head.instr;
            issue_pc_q <= head.pc;
         end
         halted_q <= (state_d == ST_HALT);
      end
   end

   // Branch context is only consumed in WAIT_BR, so it needs no reset.
   always_ff @(posedge clk) begin
      if (pop && (head_op == OP_BRANCH)) begin
         br_pc_q  <= head.pc;
         br_imm_q <= imm_b(head.instr);
      end
   end

   assign imem_en   = fetch_go;
   assign imem_addr = fetch_pc_q[IMEM_AW+1:2];
   assign push_ops  = push_q;
   assign opcode    = opcode_q;
   assign issue_pc  = issue_pc_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_riscv_fetch_issue.sv
// Testbench for riscv_fetch_issue: table-driven program scenarios on a
// 4 KB instance plus hand-written reset and wrap/run-toggle sequences on
// a second instance with a 4-word instruction memory.
module tb_riscv_fetch_issue;
   import riscv_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   logic        run1, en1, push1, bt1, halted1;
   logic [9:0]  addr1;
   logic [31:0] rdata1, op1, ipc1;

   logic        run2, en2, push2, bt2, halted2;
   logic [1:0]  addr2;
   logic [31:0] rdata2, op2, ipc2;

   logic [31:0] mem1 [0:1023];
   logic [31:0] mem2 [0:3];

   always @(posedge clk) begin
      if (en1) rdata1 <= mem1[addr1];
      if (en2) rdata2 <= mem2[addr2];
   end

   riscv_fetch_issue #(.IMEM_AW(10), .FIFO_DEPTH(4), .RESET_PC(32'h0)) u_dut (
      .clk(clk), .reset_n(reset_n), .run(run1), .imem_en(en1), .imem_addr(addr1),
      .imem_rdata(rdata1), .push_ops(push1), .opcode(op1), .issue_pc(ipc1),
      .branch_taken(bt1), .halted(halted1));

   riscv_fetch_issue #(.IMEM_AW(2), .FIFO_DEPTH(4), .RESET_PC(32'h0)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .run(run2), .imem_en(en2), .imem_addr(addr2),
      .imem_rdata(rdata2), .push_ops(push2), .opcode(op2), .issue_pc(ipc2),
      .branch_taken(bt2), .halted(halted2));

   typedef struct packed {
      logic [31:0]      w1;
      logic [31:0]      w2;
      logic             bt;
      logic             halt;
      logic [7:0]       total;
      logic [7:0]       n;
      logic [3:0][7:0]  cyc;
      logic [3:0][31:0] pc;
   } vec_t;

   vec_t vecs [5];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic set_vec(input int i, input logic [31:0] w1, input logic [31:0] w2,
                          input logic bt, input logic halt, input int total, input int n,
                          input int c0, input int c1, input int c2, input int c3,
                          input logic [31:0] p0, input logic [31:0] p1,
                          input logic [31:0] p2, input logic [31:0] p3);
      vecs[i].w1     = w1;
      vecs[i].w2     = w2;
      vecs[i].bt     = bt;
      vecs[i].halt   = halt;
      vecs[i].total  = 8'(total);
      vecs[i].n      = 8'(n);
      vecs[i].cyc[0] = 8'(c0);
      vecs[i].cyc[1] = 8'(c1);
      vecs[i].cyc[2] = 8'(c2);
      vecs[i].cyc[3] = 8'(c3);
      vecs[i].pc[0]  = p0;
      vecs[i].pc[1]  = p1;
      vecs[i].pc[2]  = p2;
      vecs[i].pc[3]  = p3;
   endtask

   // Leaves reset released #1 after an edge, so the next edge is E0.
   task automatic do_reset();
      reset_n = 1'b0;
      run1 = 1'b0;
      run2 = 1'b0;
      bt1  = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic load_mem1(input logic [31:0] w1, input logic [31:0] w2);
      for (int a = 0; a < 1024; a++) mem1[a] = 32'h00000013;
      mem1[0] = 32'h00100093;
      mem1[1] = w1;
      mem1[2] = w2;
      mem1[3] = 32'h00410213;
   endtask

   task automatic run_vec(input int i);
      vec_t        v;
      int          ev_n;
      int          plan;
      int          ev_cyc [16];
      logic [31:0] ev_pc  [16];
      logic [31:0] ev_op  [16];
      v = vecs[i];
      load_mem1(v.w1, v.w2);
      do_reset();
      ev_n = 0;
      plan = -1;
      run1 = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (push1) begin
            if (ev_n < 16) begin
               ev_cyc[ev_n] = k;
               ev_pc[ev_n]  = ipc1;
               ev_op[ev_n]  = op1;
            end
            ev_n++;
            if (op1[6:0] == OP_BRANCH) plan = k + 1;
         end
         // Core model: branch result is registered one cycle after the issue is seen.
         bt1 = (k == plan) ? v.bt : 1'b0;
      end
      run1 = 1'b0;
      bt1  = 1'b0;
      chk($sformatf("v%0d_total", i), ev_n, 32'(v.total));
      for (int j = 0; j < 4; j++) begin
         if (j < int'(v.n)) begin
            chk($sformatf("v%0d_cyc%0d", i, j), ev_cyc[j], 32'(v.cyc[j]));
            chk($sformatf("v%0d_pc%0d", i, j), ev_pc[j], v.pc[j]);
            chk($sformatf("v%0d_op%0d", i, j), ev_op[j], mem1[v.pc[j][11:2]]);
         end
      end
      chk($sformatf("v%0d_halted", i), 32'(halted1), 32'(v.halt));
      if (v.halt) begin
         repeat (3) begin
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_halt_en", i), 32'(en1), 32'd0);
            chk($sformatf("v%0d_halt_push", i), 32'(push1), 32'd0);
         end
         #2 reset_n = 1'b0;
         #1;
         chk($sformatf("v%0d_halt_rst", i), 32'(halted1), 32'd0);
      end
   endtask

   initial begin
      int          ev_n;
      int          ev_cyc [4];
      logic [31:0] ev_pc  [4];
      logic [31:0] exp_pc;
      int          n2;

      reset_n = 1'b1;
      run1 = 1'b0;
      run2 = 1'b0;
      bt1  = 1'b0;
      bt2  = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_push", 32'(push1), 32'd0);
      chk("rst_opcode", op1, 32'd0);
      chk("rst_issue_pc", ipc1, 32'd0);
      chk("rst_halted", 32'(halted1), 32'd0);
      chk("rst_imem_en", 32'(en1), 32'd0);
      chk("rst_imem_addr", 32'(addr1), 32'd0);
      chk("rst2_push", 32'(push2), 32'd0);

      //       idx w1            w2            bt    halt  tot n  cycles      pcs
      set_vec(0, 32'h00200113, 32'h00308193, 1'b0, 1'b0, 9, 4, 3, 4, 5, 6, 32'd0, 32'd4, 32'd8,  32'd12);
      set_vec(1, 32'h0080006F, 32'h00308193, 1'b0, 1'b0, 7, 4, 3, 4, 7, 8, 32'd0, 32'd4, 32'd12, 32'd16);
      set_vec(2, 32'h00000463, 32'h00308193, 1'b1, 1'b0, 5, 4, 3, 4, 9, 10, 32'd0, 32'd4, 32'd12, 32'd16);
      set_vec(3, 32'h00000463, 32'h00308193, 1'b0, 1'b0, 7, 4, 3, 4, 7, 8, 32'd0, 32'd4, 32'd8,  32'd12);
      set_vec(4, 32'h00200113, 32'h00000073, 1'b0, 1'b1, 3, 3, 3, 4, 5, 0, 32'd0, 32'd4, 32'd8,  32'd0);

      for (int i = 0; i < 5; i++) run_vec(i);

      // Reset asserted between clock edges while instructions are streaming.
      load_mem1(32'h00200113, 32'h00308193);
      do_reset();
      run1 = 1'b1;
      repeat (6) @(posedge clk);
      #3;
      chk("mid_push_before", 32'(push1), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_push", 32'(push1), 32'd0);
      chk("mid_opcode", op1, 32'd0);
      chk("mid_issue_pc", ipc1, 32'd0);
      chk("mid_imem_en", 32'(en1), 32'd0);
      chk("mid_imem_addr", 32'(addr1), 32'd0);
      chk("mid_halted", 32'(halted1), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      ev_n = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (push1) begin
            if (ev_n < 4) begin
               ev_cyc[ev_n] = k;
               ev_pc[ev_n]  = ipc1;
            end
            ev_n++;
         end
      end
      run1 = 1'b0;
      chk("restart_count", ev_n, 32'd3);
      chk("restart_cyc0", ev_cyc[0], 32'd3);
      chk("restart_pc0", ev_pc[0], 32'd0);
      chk("restart_cyc1", ev_cyc[1], 32'd4);
      chk("restart_pc1", ev_pc[1], 32'd4);

      // 4-word memory: PCs wrap 12 -> 0 while run is toggled.
      mem2[0] = 32'h00100093;
      mem2[1] = 32'h00200113;
      mem2[2] = 32'h00308193;
      mem2[3] = 32'h00410213;
      do_reset();
      exp_pc = 32'd0;
      n2 = 0;
      for (int c = 0; c < 60; c++) begin
         run2 = ((c % 6) != 3);
         @(posedge clk);
         #1;
         if (push2) begin
            chk($sformatf("wrap_pc%0d", n2), ipc2, exp_pc);
            chk($sformatf("wrap_op%0d", n2), op2, mem2[exp_pc[3:2]]);
            exp_pc = (exp_pc + 32'd4) & 32'hF;
            n2++;
         end
      end
      run2 = 1'b0;
      chk("wrap_enough_issues", 32'(n2 >= 24), 32'd1);
      chk("wrap_not_halted", 32'(halted2), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
